// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int unsigned AW_DEFAULT         = 32;
  localparam int unsigned DW_DEFAULT         = 32;
  localparam int unsigned STARVE_MAX_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_D  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_starve_ctr.sv
// Saturating count of back-to-back data grants taken while a fetch waits.
// Only instantiated when MEM_ARB_STARVE_GUARD_EN is defined.
module starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX = STARVE_MAX_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic trip
);

  localparam int unsigned CW = $clog2(MAX + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX_C)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign trip = (cnt_q == MAX_C);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) to single-port memory arbiter, data has priority.
// Define MEM_ARB_STARVE_GUARD_EN to bound fetch latency with a starvation guard.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW         = AW_DEFAULT,
  parameter int unsigned DW         = DW_DEFAULT,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          stall_f,
  output logic          stall_m,
  output logic          busy
);

  arb_state_t    state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          guard_trip;

  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (d_req && !guard_trip) begin
          state_d     = GNT_D;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
        end else if (if_req) begin
          state_d     = GNT_IF;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
        end
      end
      GNT_IF, GNT_D: begin
        if (mem_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    mem_req_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic ctr_inc, ctr_clr;

  assign ctr_inc = (state_q == IDLE) & (state_d == GNT_D) & if_req;
  assign ctr_clr = (state_q == IDLE) & (~if_req | (state_d == GNT_IF));

  starve_ctr #(
    .MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clk  (clk),
    .rst  (rst),
    .inc  (ctr_inc),
    .clr  (ctr_clr),
    .trip (guard_trip)
  );
`else
  assign guard_trip = 1'b0;
`endif

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != IDLE);

  // Acks are gated by rst so an access abandoned by reset never completes.
  assign if_ack   = ~rst & (state_q == GNT_IF) & mem_ready;
  assign d_ack    = ~rst & (state_q == GNT_D) & mem_ready;
  assign if_rdata = (state_q == GNT_IF) ? mem_rdata : '0;
  assign d_rdata  = (state_q == GNT_D) ? mem_rdata : '0;

  assign stall_f = if_req & ~if_ack;
  assign stall_m = d_req & ~d_ack;

endmodule
